// File: rtl/fir_stream_pkg.sv
// Shared types and defaults for the FIR sample streamer.
package fir_stream_pkg;

  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned DEF_DEPTH   = 8;
  localparam int unsigned DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/fir_stream_fifo.sv
// Synchronous FIFO with registered read port; the extra pointer bit tells full from empty.
module fir_stream_fifo
  import fir_stream_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_W,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/fir_stream_ctrl.sv
// One-sample-in-flight streamer between bus FIFOs and the 8-tap FIR.
// Optional WAIT timeout and sticky error flag: define FIR_STREAM_TIMEOUT_EN.
module fir_stream_ctrl
  import fir_stream_pkg::*;
#(
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   wr_en,
  input  logic [SAMPLE_W-1:0]    wr_data,
  output logic                   in_full,
  input  logic                   rd_en,
  output logic [SAMPLE_W-1:0]    rd_data,
  output logic                   out_empty,
  output logic [$clog2(DEPTH):0] out_count,
  output logic [SAMPLE_W-1:0]    fir_data_in,
  output logic                   fir_data_in_ready,
  input  logic [SAMPLE_W-1:0]    fir_data_out,
  input  logic                   fir_data_out_flag,
  output logic                   busy,
  output logic                   timeout_err,
  input  logic                   clr_err
);

  state_t                 state;
  state_t                 state_nx;
  logic                   issue;
  logic                   push_res;
  logic                   to_hit;
  logic                   in_empty;
  logic                   out_full;
  logic [$clog2(DEPTH):0] in_count_unused;

  // The input FIFO's registered read port doubles as the fir_data_in holding register.
  fir_stream_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_in_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (issue),
    .rd_data (fir_data_in),
    .full    (in_full),
    .empty   (in_empty),
    .count   (in_count_unused)
  );

  fir_stream_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_res),
    .wr_data (fir_data_out),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (out_full),
    .empty   (out_empty),
    .count   (out_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    push_res = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && !in_empty && !out_full) begin
          issue    = 1'b1;
          state_nx = ISSUE;
        end
      end
      // A stale flag from the previous result may still be high here.
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (fir_data_out_flag) begin
          push_res = 1'b1;
          state_nx = IDLE;
        end else if (to_hit) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign fir_data_in_ready = (state == ISSUE);
  assign busy              = (state != IDLE);

`ifdef FIR_STREAM_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] to_cnt;
  logic          err_q;

  assign to_hit = (state == WAIT) && !fir_data_out_flag && (to_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state == ISSUE) begin
      to_cnt <= '0;
    end else if (state == WAIT) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (to_hit) begin
      err_q <= 1'b1;
    end else if (clr_err) begin
      err_q <= 1'b0;
    end
  end

  assign timeout_err = err_q;
`else
  logic [1:0] cfg_unused;

  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
  assign cfg_unused  = {clr_err, TIMEOUT != 0};
`endif

endmodule
